// File: rtl/restoring_divider_32by16.sv
// Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor.
// Produces one quotient bit per clock behind a start/busy/done handshake.
// Results and error flags are held until the next accepted start.
module restoring_divider_32by16 #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    // ERR is a one-cycle holding state so error results land on the same
    // edge offset (E0+1) as a one-iteration operation would.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_reg;
    logic [N-1:0]  divisor_reg;
    logic [N-1:0]  rem_reg;
    logic [N-1:0]  quo_reg;
    logic [CW-1:0] cnt_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [N-1:0]  quotient_reg;
    logic [N-1:0]  remainder_reg;
    logic          div_by_zero_reg;
    logic          overflow_reg;

    // Partial remainder is kept at N bits: it is always below the divisor,
    // so the (N+1)-bit shifted value only needs its top bit for the compare.
    logic [N:0]    shifted;
    logic          borrow;
    logic [N-1:0]  diff;
    logic [N-1:0]  rem_next;
    logic [N-1:0]  quo_next;
    logic          start_error;

    // One restoring step: shift in the next dividend bit, trial-subtract.
    always_comb begin
        shifted  = {rem_reg, quo_reg[N-1]};
        borrow   = (shifted < {1'b0, divisor_reg});
        // When there is no borrow the difference is below the divisor, so
        // the N-bit wrapped subtraction is exact.
        diff     = shifted[N-1:0] - divisor_reg;
        rem_next = borrow ? shifted[N-1:0] : diff;
        quo_next = {quo_reg[N-2:0], ~borrow};
    end

    // A zero divisor always satisfies the high-half compare as well, so one
    // test covers both error kinds; ERR sorts them apart.
    always_comb begin
        start_error = (divisor == '0) || (dividend[2*N-1:N] >= divisor);
    end

    // Control FSM and datapath registers; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            divisor_reg     <= '0;
            rem_reg         <= '0;
            quo_reg         <= '0;
            cnt_reg         <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            div_by_zero_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                    if (start) begin
                        divisor_reg     <= divisor;
                        rem_reg         <= dividend[2*N-1:N];
                        quo_reg         <= dividend[N-1:0];
                        cnt_reg         <= '0;
                        div_by_zero_reg <= 1'b0;
                        overflow_reg    <= 1'b0;
                        if (start_error) begin
                            state_reg <= ERR;
                        end else begin
                            state_reg <= RUN;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_ITER) begin
                        quotient_reg  <= quo_next;
                        remainder_reg <= rem_next;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                ERR: begin
                    // quo_reg still holds the low half of the dividend here.
                    quotient_reg <= '1;
                    if (divisor_reg == '0) begin
                        div_by_zero_reg <= 1'b1;
                        remainder_reg   <= quo_reg;
                    end else begin
                        overflow_reg  <= 1'b1;
                        remainder_reg <= '0;
                    end
                    done_reg  <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = div_by_zero_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_restoring_divider_32by16.sv
// Self-checking bench for restoring_divider_32by16: directed vector table,
// hand-written corner sequences, and a held-start random run.
module tb_restoring_divider_32by16;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   dividend;
    logic [15:0]   divisor;
    logic          busy;
    logic          done;
    logic [15:0]   quotient;
    logic [15:0]   remainder;
    logic          div_by_zero;
    logic          overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    restoring_divider_32by16 #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dvd;
        logic [15:0] dvs;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one start pulse and wait for done; operands are scrambled after
    // acceptance to show they are captured.
    task automatic do_op(input logic [31:0] dvd, input logic [15:0] dvs,
                         output bit got, output int lat, output int busy_cnt);
        got = 0;
        lat = -1;
        busy_cnt = 0;
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        step();
        start    = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
        check("flags_clear_on_start", {30'd0, div_by_zero, overflow}, 32'd0);
        for (int k = 0; k < 40; k++) begin
            if (busy && done) check("busy_done_exclusive", 32'd1, 32'd0);
            if (done) begin
                got = 1;
                lat = k;
                break;
            end
            busy_cnt += int'(busy);
            step();
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
        else begin
            step();
            check("done_one_cycle", {31'd0, done}, 32'd0);
        end
    endtask

    bit          got;
    int          lat;
    int          bcnt;
    int          k;
    logic [31:0] cur_dvd;
    logic [15:0] cur_dvs;
    bit          cur_err;
    int          gap;
    int          sel;

    initial begin
        //            dividend       divisor   q        r        dz    ov
        vecs[0]  = '{32'd1000,      16'd7,    16'd142, 16'd6,   1'b0, 1'b0};
        vecs[1]  = '{32'hFFFE0001,  16'hFFFF, 16'hFFFF, 16'h0,  1'b0, 1'b0};
        vecs[2]  = '{32'h12345678,  16'h0,    16'hFFFF, 16'h5678, 1'b1, 1'b0};
        vecs[3]  = '{32'h00010000,  16'd1,    16'hFFFF, 16'h0,  1'b0, 1'b1};
        vecs[4]  = '{32'd5,         16'd2,    16'd2,   16'd1,   1'b0, 1'b0};
        vecs[5]  = '{32'd0,         16'd5,    16'd0,   16'd0,   1'b0, 1'b0};
        vecs[6]  = '{32'h0000FFFF,  16'h0100, 16'h00FF, 16'h00FF, 1'b0, 1'b0};
        vecs[7]  = '{32'h7FFFFFFF,  16'h8000, 16'hFFFF, 16'h7FFF, 1'b0, 1'b0};
        vecs[8]  = '{32'h00030000,  16'd3,    16'hFFFF, 16'h0,  1'b0, 1'b1};
        vecs[9]  = '{32'h0002FFFF,  16'd3,    16'hFFFF, 16'd2,  1'b0, 1'b0};
        vecs[10] = '{32'd100,       16'd1,    16'd100, 16'd0,   1'b0, 1'b0};
        vecs[11] = '{32'hFFFFFFFF,  16'hFFFF, 16'hFFFF, 16'h0,  1'b0, 1'b1};

        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        step(); step();
        reset = 1'b0;
        check("reset_outputs", {12'd0, busy, done, div_by_zero, overflow, quotient},
              32'd0);
        check("reset_remainder", {16'd0, remainder}, 32'd0);

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].dvd, vecs[i].dvs, got, lat, bcnt);
            $display("vec %0d: 0x%08h / 0x%04h -> q=0x%04h r=0x%04h dz=%0b ov=%0b lat=%0d",
                     i, vecs[i].dvd, vecs[i].dvs, quotient, remainder, div_by_zero, overflow, lat);
            check("vec_quotient",  {16'd0, quotient},  {16'd0, vecs[i].q});
            check("vec_remainder", {16'd0, remainder}, {16'd0, vecs[i].r});
            check("vec_div_by_zero", {31'd0, div_by_zero}, {31'd0, vecs[i].dz});
            check("vec_overflow",  {31'd0, overflow},  {31'd0, vecs[i].ov});
            check("vec_latency", lat, (vecs[i].dz || vecs[i].ov) ? 32'd1 : 32'(N));
            check("vec_busy_cycles", bcnt, (vecs[i].dz || vecs[i].ov) ? 32'd0 : 32'(N));
        end

        // Start pulse mid-RUN must be ignored and not queued.
        dividend = 32'd1000; divisor = 16'd7; start = 1'b1;
        step();
        start = 1'b0;
        got = 0; lat = -1;
        for (k = 0; k < 40; k++) begin
            if (done) begin got = 1; lat = k; break; end
            if (k == 3) begin start = 1'b1; dividend = 32'h5555; divisor = 16'd3; end
            if (k == 4) start = 1'b0;
            step();
        end
        $display("midrun start: q=%0d r=%0d lat=%0d", quotient, remainder, lat);
        check("midrun_latency", lat, 32'(N));
        check("midrun_quotient", {16'd0, quotient}, 32'd142);
        check("midrun_remainder", {16'd0, remainder}, 32'd6);
        gap = 0;
        for (int j = 0; j < 2 * N; j++) begin
            step();
            gap += int'(done) + int'(busy);
        end
        check("midrun_not_queued", gap, 32'd0);

        // Reset during RUN aborts with no done.
        dividend = 32'h12345678; divisor = 16'h4321; start = 1'b1;
        step();
        start = 1'b0;
        for (k = 0; k < 8; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        $display("reset mid-run: busy=%0b done=%0b q=0x%04h r=0x%04h", busy, done, quotient, remainder);
        check("abort_outputs", {12'd0, busy, done, div_by_zero, overflow, quotient}, 32'd0);
        check("abort_remainder", {16'd0, remainder}, 32'd0);
        gap = 0;
        for (int j = 0; j < N + 4; j++) begin
            step();
            gap += int'(done) + int'(busy);
        end
        check("abort_no_done", gap, 32'd0);
        do_op(32'd1000, 16'd7, got, lat, bcnt);
        $display("after abort: q=%0d r=%0d lat=%0d", quotient, remainder, lat);
        check("fresh_quotient", {16'd0, quotient}, 32'd142);
        check("fresh_remainder", {16'd0, remainder}, 32'd6);
        check("fresh_latency", lat, 32'(N));

        // Start held high: back-to-back random operations.
        start = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            sel = $urandom_range(0, 7);
            cur_dvs = 16'($urandom);
            if (sel == 0) cur_dvs = 16'd0;
            else if (cur_dvs == 16'd0) cur_dvs = 16'd1;
            if (sel == 1) cur_dvd = {16'hFFFF, 16'($urandom)};
            else if (sel == 0) cur_dvd = $urandom;
            else cur_dvd = {16'($urandom) % cur_dvs, 16'($urandom)};
            cur_err = (cur_dvs == 16'd0) || (cur_dvd[31:16] >= cur_dvs);
            dividend = cur_dvd;
            divisor  = cur_dvs;
            gap = 0;
            do begin
                step();
                gap++;
                if (busy && done) check("held_busy_done_exclusive", 32'd1, 32'd0);
            end while (!done && gap < 60);
            $display("held %0d: 0x%08h / 0x%04h -> q=0x%04h r=0x%04h dz=%0b ov=%0b gap=%0d",
                     i, cur_dvd, cur_dvs, quotient, remainder, div_by_zero, overflow, gap);
            if (!done) begin
                check("held_timeout", 32'd0, 32'd1);
                break;
            end
            check("held_gap", gap, (cur_err ? 32'd1 : 32'(N)) + ((i == 0) ? 32'd1 : 32'd2));
            if (cur_dvs == 16'd0) begin
                check("held_dz", {30'd0, div_by_zero, overflow}, 32'd2);
                check("held_dz_q", {quotient, remainder}, {16'hFFFF, cur_dvd[15:0]});
            end else if (cur_err) begin
                check("held_ov", {30'd0, div_by_zero, overflow}, 32'd1);
                check("held_ov_q", {quotient, remainder}, {16'hFFFF, 16'h0});
            end else begin
                check("held_flags", {30'd0, div_by_zero, overflow}, 32'd0);
                check("held_invariant", 32'(quotient) * 32'(cur_dvs) + 32'(remainder), cur_dvd);
                check("held_rem_lt_div", {31'd0, remainder < cur_dvs}, 32'd1);
            end
        end
        start = 1'b0;
        step(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
